// File: rtl/delay_timer_pkg.sv
// delay_timer shared constants: FSM encoding, default width, unit select.
// Optional build macro: DELAY_TIMER_PERIODIC_EN.
package delay_timer_pkg;

  localparam int DT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic UNIT_US = 1'b0;
  localparam logic UNIT_MS = 1'b1;

endpackage

// File: rtl/delay_timer_if.sv
// Start/busy/done handshake between a sequencer and delay_timer.
// DELAY_TIMER_PERIODIC_EN adds the periodic request bit.
interface delay_timer_if #(
  parameter int WIDTH = delay_timer_pkg::DT_WIDTH
);
  logic             start;
  logic             unit_ms;
  logic [WIDTH-1:0] delay;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;
`ifdef DELAY_TIMER_PERIODIC_EN
  logic             periodic;

  modport master (
    output start, unit_ms, delay, abort, periodic,
    input  busy, done, remaining
  );
  modport slave (
    input  start, unit_ms, delay, abort, periodic,
    output busy, done, remaining
  );
`else
  modport master (
    output start, unit_ms, delay, abort,
    input  busy, done, remaining
  );
  modport slave (
    input  start, unit_ms, delay, abort,
    output busy, done, remaining
  );
`endif
endinterface

// File: rtl/delay_timer_tick_down_counter.sv
// Loadable down counter that saturates at zero.
// term flags a count of one so the FSM can see the final tick.
module tick_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign term  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/delay_timer.sv
// Programmable delay timed by us/ms ticks, start/busy/done handshake.
// DELAY_TIMER_PERIODIC_EN enables auto-reload periodic mode.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int WIDTH = DT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          us_tck,
  input  logic          ms_tck,
  delay_timer_if.slave  tif
);

  logic [1:0]       state_q, state_d;
  logic             unit_q, unit_d;
  logic             done_q, done_d;
  logic             tick;
  logic             cnt_clr, cnt_load, cnt_dec;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             term;
`ifdef DELAY_TIMER_PERIODIC_EN
  logic             periodic_q, periodic_d;
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign tick = (unit_q == UNIT_MS) ? ms_tck : us_tck;

  always_comb begin
    state_d  = state_q;
    unit_d   = unit_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    load_val = tif.delay;
`ifdef DELAY_TIMER_PERIODIC_EN
    periodic_d = periodic_q;
    reload_d   = reload_q;
`endif
    priority case (1'b1)
      tif.abort: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      state_q == ST_RUN: begin
        if (tick && term) begin
          done_d = 1'b1;
`ifdef DELAY_TIMER_PERIODIC_EN
          if (periodic_q) begin
            cnt_load = 1'b1;
            load_val = reload_q;
          end else begin
            state_d = ST_DONE;
            cnt_dec = 1'b1;
          end
`else
          state_d = ST_DONE;
          cnt_dec = 1'b1;
`endif
        end else if (tick) begin
          cnt_dec = 1'b1;
        end
      end
      tif.start && tif.delay == '0: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        cnt_clr = 1'b1;
`ifdef DELAY_TIMER_PERIODIC_EN
        periodic_d = 1'b0;
`endif
      end
      tif.start: begin
        state_d  = ST_RUN;
        unit_d   = tif.unit_ms;
        cnt_load = 1'b1;
`ifdef DELAY_TIMER_PERIODIC_EN
        periodic_d = tif.periodic;
        reload_d   = tif.delay;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      unit_q  <= UNIT_US;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      done_q  <= done_d;
    end
  end

`ifdef DELAY_TIMER_PERIODIC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      periodic_q <= 1'b0;
      reload_q   <= '0;
    end else begin
      periodic_q <= periodic_d;
      reload_q   <= reload_d;
    end
  end
`endif

  tick_down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .term     (term)
  );

  assign tif.busy      = (state_q == ST_RUN);
  assign tif.done      = done_q;
  assign tif.remaining = cnt;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer with hand-computed expectations.
// Periodic checks run when DELAY_TIMER_PERIODIC_EN is defined.
module tb_delay_timer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic us_tck;
  logic ms_tck;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  delay_timer_if #(.WIDTH(W)) dif ();

  delay_timer #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .us_tck (us_tck),
    .ms_tck (ms_tck),
    .tif    (dif)
  );

  task automatic expect_eq(input string tag,
                           input int got,
                           input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
               tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input int b,
                     input int d, input int r);
    expect_eq({tag, ".busy"}, int'(dif.busy), b);
    expect_eq({tag, ".done"}, int'(dif.done), d);
    expect_eq({tag, ".rem"}, int'(dif.remaining), r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic u, input logic m,
                      input int gap);
    repeat (gap) cyc();
    us_tck = u;
    ms_tck = m;
    cyc();
    us_tck = 1'b0;
    ms_tck = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    us_tck      = 1'b0;
    ms_tck      = 1'b0;
    dif.start   = 1'b0;
    dif.unit_ms = 1'b0;
    dif.delay   = '0;
    dif.abort   = 1'b0;
`ifdef DELAY_TIMER_PERIODIC_EN
    dif.periodic = 1'b0;
`endif
    repeat (3) cyc();
    chk("reset", 0, 0, 0);
    rst = 1'b1;
    cyc();
    chk("idle", 0, 0, 0);

    // delay 3 in us; tick alongside start is ignored
    dif.start = 1'b1;
    dif.delay = 16'd3;
    us_tck    = 1'b1;
    cyc();
    dif.start = 1'b0;
    us_tck    = 1'b0;
    chk("us3.load", 1, 0, 3);
    tick(1'b1, 1'b0, 25);
    chk("us3.t1", 1, 0, 2);
    tick(1'b1, 1'b0, 25);
    chk("us3.t2", 1, 0, 1);
    tick(1'b1, 1'b0, 25);
    chk("us3.t3", 0, 1, 0);
    cyc();
    chk("us3.after", 0, 0, 0);

    // zero delay completes immediately
    dif.start = 1'b1;
    dif.delay = 16'd0;
    cyc();
    dif.start = 1'b0;
    chk("zero.done", 0, 1, 0);
    cyc();
    chk("zero.after", 0, 0, 0);

    // delay 1 boundary
    dif.start = 1'b1;
    dif.delay = 16'd1;
    cyc();
    dif.start = 1'b0;
    chk("one.load", 1, 0, 1);
    tick(1'b1, 1'b0, 2);
    chk("one.t1", 0, 1, 0);
    cyc();
    chk("one.after", 0, 0, 0);

    // ms unit: us ticks must not count
    dif.start   = 1'b1;
    dif.delay   = 16'd2;
    dif.unit_ms = 1'b1;
    cyc();
    dif.start   = 1'b0;
    dif.unit_ms = 1'b0;
    chk("ms2.load", 1, 0, 2);
    tick(1'b1, 1'b0, 3);
    chk("ms2.us", 1, 0, 2);
    tick(1'b1, 1'b1, 3);
    chk("ms2.both", 1, 0, 1);
    tick(1'b1, 1'b0, 2);
    chk("ms2.us2", 1, 0, 1);
    tick(1'b0, 1'b1, 3);
    chk("ms2.t2", 0, 1, 0);
    cyc();
    chk("ms2.after", 0, 0, 0);

    // abort mid-count
    dif.start = 1'b1;
    dif.delay = 16'd5;
    cyc();
    dif.start = 1'b0;
    tick(1'b1, 1'b0, 2);
    tick(1'b1, 1'b0, 2);
    chk("ab.run", 1, 0, 3);
    dif.abort = 1'b1;
    cyc();
    dif.abort = 1'b0;
    chk("ab.idle", 0, 0, 0);
    cyc();
    chk("ab.nodone", 0, 0, 0);
    dif.start = 1'b1;
    dif.abort = 1'b1;
    dif.delay = 16'd4;
    cyc();
    dif.start = 1'b0;
    dif.abort = 1'b0;
    chk("ab.prio", 0, 0, 0);

    // start in RUN ignored, then async reset
    dif.start = 1'b1;
    dif.delay = 16'd6;
    cyc();
    dif.start = 1'b0;
    tick(1'b1, 1'b0, 2);
    tick(1'b1, 1'b0, 2);
    chk("rs.run", 1, 0, 4);
    dif.start = 1'b1;
    dif.delay = 16'd9;
    cyc();
    dif.start = 1'b0;
    chk("rs.ignore", 1, 0, 4);
    #2;
    rst = 1'b0;
    #1;
    chk("rs.async", 0, 0, 0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1);
      expect_eq("rs.nodone", int'(dif.done), 0);
    end
    chk("rs.idle", 0, 0, 0);

`ifdef DELAY_TIMER_PERIODIC_EN
    dif.start    = 1'b1;
    dif.delay    = 16'd2;
    dif.periodic = 1'b1;
    cyc();
    dif.start    = 1'b0;
    dif.periodic = 1'b0;
    chk("per.load", 1, 0, 2);
    for (int p = 0; p < 3; p++) begin
      tick(1'b1, 1'b0, 2);
      chk("per.half", 1, 0, 1);
      tick(1'b1, 1'b0, 2);
      chk("per.wrap", 1, 1, 2);
      cyc();
      chk("per.hold", 1, 0, 2);
    end
    dif.abort = 1'b1;
    cyc();
    dif.abort = 1'b0;
    chk("per.abort", 0, 0, 0);
    tick(1'b1, 1'b0, 1);
    tick(1'b1, 1'b0, 1);
    chk("per.quiet", 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
